// File: rtl/routing_unit_buffered.sv
// routing_unit_buffered: per-input-port FIFO plus XY route computation for the
// 2D mesh router. The head packet is routed, then a one-hot request is held
// toward the crossbar arbiter until a matching grant pops it.
module routing_unit_buffered #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned COORD_W    = 8,
    parameter int unsigned HOP_W      = 4,
    parameter int unsigned CUR_X      = 0,
    parameter int unsigned CUR_Y      = 0,
    parameter int unsigned DIR_X_BIT  = 62,
    parameter int unsigned DIR_Y_BIT  = 61,
    parameter int unsigned HOP_X_LSB  = 52,
    parameter int unsigned HOP_Y_LSB  = 48,
    parameter int unsigned SRC_X_LSB  = 40,
    parameter int unsigned SRC_Y_LSB  = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic [4:0]             out_req,
    output logic [DATA_WIDTH-1:0]  out_data,
    input  logic [4:0]             out_gnt,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    localparam logic [4:0] REQ_L  = 5'b00001;
    localparam logic [4:0] REQ_R  = 5'b00010;
    localparam logic [4:0] REQ_U  = 5'b00100;
    localparam logic [4:0] REQ_D  = 5'b01000;
    localparam logic [4:0] REQ_PE = 5'b10000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUTE = 2'd1,
        S_REQ   = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [OCC_W-1:0]      r_occ;
    state_t                r_state;
    logic [4:0]            r_out_req;
    logic [DATA_WIDTH-1:0] r_out_data;

    state_t                w_state_nxt;
    logic [4:0]            w_req_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  w_push;
    logic                  w_pop;
    logic [OCC_W-1:0]      w_occ_nxt;
    logic [DATA_WIDTH-1:0] w_head;
    logic [COORD_W-1:0]    w_src_x;
    logic [COORD_W-1:0]    w_src_y;
    logic [COORD_W-1:0]    w_hop_x;
    logic [COORD_W-1:0]    w_hop_y;
    logic [COORD_W-1:0]    w_tx;
    logic [COORD_W-1:0]    w_ty;
    logic [4:0]            w_route;

    // Handshake and occupancy bookkeeping; a full FIFO never accepts, even while popping.
    assign in_ready  = reset_n && (r_occ < OCC_W'(DEPTH));
    assign w_push    = in_valid && in_ready;
    assign w_pop     = (r_state == S_REQ) && ((out_gnt & r_out_req) != 5'b00000);
    assign w_occ_nxt = r_occ + OCC_W'(w_push) - OCC_W'(w_pop);

    assign occupancy = r_occ;
    assign out_req   = r_out_req;
    assign out_data  = r_out_data;

    // Target coordinate of the head packet (mod 2^COORD_W) and its XY direction.
    always_comb begin
        w_head  = r_mem[r_rd_ptr];
        w_src_x = w_head[SRC_X_LSB +: COORD_W];
        w_src_y = w_head[SRC_Y_LSB +: COORD_W];
        w_hop_x = COORD_W'(w_head[HOP_X_LSB +: HOP_W]);
        w_hop_y = COORD_W'(w_head[HOP_Y_LSB +: HOP_W]);
        w_tx    = w_head[DIR_X_BIT] ? (w_src_x + w_hop_x) : (w_src_x - w_hop_x);
        w_ty    = w_head[DIR_Y_BIT] ? (w_src_y + w_hop_y) : (w_src_y - w_hop_y);
        w_route = REQ_PE;
        if (w_tx != COORD_W'(CUR_X)) begin
            w_route = w_head[DIR_X_BIT] ? REQ_R : REQ_L;
        end else if (w_ty != COORD_W'(CUR_Y)) begin
            w_route = w_head[DIR_Y_BIT] ? REQ_U : REQ_D;
        end
    end

    // FIFO storage write; not reset, contents are qualified by occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_occ <= w_occ_nxt;
        end
    end

    // Next-state and registered-output logic for the route/request sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_out_req;
        w_data_nxt  = r_out_data;
        case (r_state)
            S_IDLE: begin
                if (r_occ != '0) begin
                    w_state_nxt = S_ROUTE;
                end
            end
            S_ROUTE: begin
                w_req_nxt   = w_route;
                w_data_nxt  = w_head;
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (w_pop) begin
                    w_req_nxt   = 5'b00000;
                    w_data_nxt  = '0;
                    w_state_nxt = (w_occ_nxt != '0) ? S_ROUTE : S_IDLE;
                end
            end
            default: begin
                w_req_nxt   = 5'b00000;
                w_data_nxt  = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and request registers; reset flushes any outstanding request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_out_req  <= 5'b00000;
            r_out_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_out_req  <= w_req_nxt;
            r_out_data <= w_data_nxt;
        end
    end

endmodule

// File: tb/tb_routing_unit_buffered.sv
// Bench for routing_unit_buffered (CUR_X=2, CUR_Y=1, DEPTH=4): directed cases
// followed by random traffic, all checked against a packet-queue reference model.
module tb_routing_unit_buffered;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [4:0]  out_req;
    logic [63:0] out_data;
    logic [4:0]  out_gnt;
    logic [2:0]  occupancy;

    routing_unit_buffered #(
        .DATA_WIDTH(64), .DEPTH(DEPTH), .COORD_W(8), .HOP_W(4),
        .CUR_X(2), .CUR_Y(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_req(out_req), .out_data(out_data), .out_gnt(out_gnt),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: accepted packets in order, plus the request being shown.
    logic [63:0] m_q[$];
    bit          m_active;
    bit          m_pending;
    logic [4:0]  m_req;
    logic [63:0] m_data;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input bit dx, input int sx, input int hx,
                                       input bit dy, input int sy, input int hy,
                                       input logic [31:0] id);
        logic [63:0] p;
        p = '0;
        p[62]    = dx;
        p[61]    = dy;
        p[55:52] = 4'(hx);
        p[51:48] = 4'(hy);
        p[47:40] = 8'(sx);
        p[39:32] = 8'(sy);
        p[31:0]  = id;
        return p;
    endfunction

    // XY routing from plain integer arithmetic on the packet fields.
    function automatic logic [4:0] ref_route(input logic [63:0] p);
        int sx, sy, hx, hy, tx, ty;
        sx = int'(p[47:40]);
        sy = int'(p[39:32]);
        hx = int'(p[55:52]);
        hy = int'(p[51:48]);
        tx = p[62] ? (sx + hx) % 256 : (sx - hx + 256) % 256;
        ty = p[61] ? (sy + hy) % 256 : (sy - hy + 256) % 256;
        if (tx != 2) return p[62] ? 5'b00010 : 5'b00001;
        if (ty != 1) return p[61] ? 5'b00100 : 5'b01000;
        return 5'b10000;
    endfunction

    // One clock: drive inputs, advance the model across the edge, compare after it.
    task automatic step(input logic v, input logic [63:0] d, input logic [4:0] g, input logic rn);
        bit push;
        int size_pre;
        in_valid = v;
        in_data  = d;
        out_gnt  = g;
        reset_n  = rn;
        size_pre = m_q.size();
        push = v && rn && (size_pre < DEPTH);
        if (!rn) begin
            m_q.delete();
            m_active = 0; m_pending = 0;
            m_req = '0; m_data = '0;
        end else begin
            if (m_active && ((g & m_req) != 5'b0)) begin
                void'(m_q.pop_front());
                if (push) m_q.push_back(d);
                m_active = 0;
                m_req = '0; m_data = '0;
                m_pending = (m_q.size() > 0);
            end else begin
                if (!m_active) begin
                    if (m_pending) begin
                        m_active  = 1;
                        m_pending = 0;
                        m_req  = ref_route(m_q[0]);
                        m_data = m_q[0];
                    end else begin
                        m_pending = (size_pre > 0);
                    end
                end
                if (push) m_q.push_back(d);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_val("out_req", 64'(out_req), 64'(m_req));
        check_val("out_data", out_data, m_data);
        check_val("occupancy", 64'(occupancy), 64'(m_q.size()));
        check_val("in_ready", 64'(in_ready), 64'(rn && (m_q.size() < DEPTH)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 64'h0, 5'b0, 1'b1);
    endtask

    function automatic logic [63:0] rand_pkt();
        logic [63:0] p;
        p = {$urandom, $urandom};
        if ($urandom_range(0, 3) != 0) begin
            p[47:40] = 8'($urandom_range(0, 5));
            p[39:32] = 8'($urandom_range(0, 3));
            p[55:52] = 4'($urandom_range(0, 4));
            p[51:48] = 4'($urandom_range(0, 3));
        end
        return p;
    endfunction

    initial begin
        logic [63:0] p1, p2, p3;
        logic [4:0]  g;
        in_valid = 0; in_data = '0; out_gnt = '0; reset_n = 0;
        m_active = 0; m_pending = 0; m_req = '0; m_data = '0;
        @(negedge clk);

        // Reset state
        step(1'b0, 64'h0, 5'b0, 1'b0);
        step(1'b1, 64'h1234, 5'b0, 1'b0);
        check_val("rst_req", 64'(out_req), 64'h0);
        check_val("rst_occ", 64'(occupancy), 64'h0);
        check_val("rst_in_ready", 64'(in_ready), 64'h0);
        idle(1);

        // Local delivery: target equals this router, request two edges after accept
        p1 = mk(1, 0, 2, 1, 0, 1, 32'hA001);
        step(1'b1, p1, 5'b0, 1'b1);
        idle(1);
        check_val("pe_not_yet", 64'(out_req), 64'h0);
        idle(1);
        check_val("pe_req", 64'(out_req), 64'h10);
        check_val("pe_data", out_data, p1);
        step(1'b0, 64'h0, 5'b10000, 1'b1);
        check_val("pe_occ", 64'(occupancy), 64'h0);
        idle(2);
        check_val("pe_idle_req", 64'(out_req), 64'h0);

        // West then down
        p1 = mk(0, 5, 1, 0, 0, 0, 32'hB001);
        p2 = mk(0, 3, 1, 0, 3, 1, 32'hB002);
        step(1'b1, p1, 5'b0, 1'b1);
        step(1'b1, p2, 5'b0, 1'b1);
        idle(1);
        check_val("l_req", 64'(out_req), 64'h01);
        step(1'b0, 64'h0, 5'b00001, 1'b1);
        idle(1);
        check_val("d_req", 64'(out_req), 64'h08);
        check_val("d_data", out_data, p2);
        step(1'b0, 64'h0, 5'b01000, 1'b1);
        idle(2);

        // Coordinate wrap-around: 0xFA + 8 = 0x02
        p1 = mk(1, 8'hFA, 8, 1, 1, 0, 32'hC001);
        step(1'b1, p1, 5'b0, 1'b1);
        idle(2);
        check_val("wrap_req", 64'(out_req), 64'h10);
        step(1'b0, 64'h0, 5'b10000, 1'b1);
        idle(2);

        // Backpressure: five offers, four accepted, grant filtering, no fall-through
        for (int i = 1; i <= 5; i++) step(1'b1, mk(1, 0, 1, 0, 0, 0, 32'(i)), 5'b0, 1'b1);
        check_val("bp_occ", 64'(occupancy), 64'h4);
        check_val("bp_ready", 64'(in_ready), 64'h0);
        step(1'b1, mk(1, 0, 1, 0, 0, 0, 32'h99), 5'b11101, 1'b1);
        check_val("bp_wrong_gnt_occ", 64'(occupancy), 64'h4);
        step(1'b1, mk(1, 0, 1, 0, 0, 0, 32'h98), 5'b00010, 1'b1);
        check_val("bp_pop_occ", 64'(occupancy), 64'h3);
        step(1'b0, 64'h0, 5'b00010, 1'b1);
        check_val("bp_next_id", 64'(out_data[31:0]), 64'h2);
        for (int i = 0; i < 8; i++) step(1'b0, 64'h0, 5'b00010, 1'b1);
        check_val("bp_drained", 64'(occupancy), 64'h0);

        // Simultaneous push and pop at occupancy 2
        p1 = mk(0, 5, 1, 0, 0, 0, 32'hD001);
        p2 = mk(0, 3, 1, 0, 3, 1, 32'hD002);
        p3 = mk(1, 0, 2, 1, 0, 1, 32'hD003);
        step(1'b1, p1, 5'b0, 1'b1);
        step(1'b1, p2, 5'b0, 1'b1);
        idle(1);
        check_val("pp_occ_before", 64'(occupancy), 64'h2);
        step(1'b1, p3, 5'b00001, 1'b1);
        check_val("pp_occ_after", 64'(occupancy), 64'h2);
        idle(1);
        check_val("pp_second", out_data, p2);
        for (int i = 0; i < 6; i++) step(1'b0, 64'h0, 5'b11111, 1'b1);

        // Reset while requesting with three packets buffered
        for (int i = 0; i < 3; i++) step(1'b1, mk(1, 0, 1, 0, 0, 0, 32'(i + 16'hE0)), 5'b0, 1'b1);
        check_val("mr_occ3", 64'(occupancy), 64'h3);
        step(1'b0, 64'h0, 5'b0, 1'b0);
        check_val("mr_req", 64'(out_req), 64'h0);
        check_val("mr_occ", 64'(occupancy), 64'h0);
        check_val("mr_ready_low", 64'(in_ready), 64'h0);
        reset_n = 1'b1;
        #1;
        check_val("mr_ready_high", 64'(in_ready), 64'h1);
        idle(3);
        check_val("mr_idle_req", 64'(out_req), 64'h0);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            case ($urandom_range(0, 3))
                0:       g = m_req;
                1:       g = 5'($urandom_range(0, 31));
                default: g = 5'b0;
            endcase
            step(1'($urandom_range(0, 2) != 0), rand_pkt(), g, 1'($urandom_range(0, 299) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
